// File: rtl/mxdiv_sched_pkg.sv
// Shared definitions for the matrix-divide scheduler: state encodings,
// error codes and the default watchdog limit.
package mxdiv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INV_START = 3'd1,
    INV_WAIT  = 3'd2,
    MUL_START = 3'd3,
    MUL_WAIT  = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_SINGULAR    = 2'b01;
  localparam logic [1:0] ERR_INV_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_MUL_TIMEOUT = 2'b11;

  localparam int TIMEOUT_DEFAULT = 63;
  localparam int WDOG_WIDTH      = 8;

  function automatic logic isWaitState(input state_t s);
    return (s == INV_WAIT) || (s == MUL_WAIT);
  endfunction

  function automatic logic isLaunchState(input state_t s);
    return (s == INV_START) || (s == MUL_START);
  endfunction

endpackage

// File: rtl/mxdiv_wdog.sv
// Saturating watchdog for the scheduler's wait phases; expired flags the
// cycle whose increment would make the count reach LIMIT.
module mxdiv_wdog
  import mxdiv_sched_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_WIDTH-1:0] LIMIT_M1 = WDOG_WIDTH'(LIMIT - 1);
  localparam logic [WDOG_WIDTH-1:0] SAT_MAX  = {WDOG_WIDTH{1'b1}};

  logic [WDOG_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // The wait state lasts exactly LIMIT cycles, so expiry is judged on the
  // pre-increment value.
  assign expired = enable && (count >= LIMIT_M1);

endmodule

// File: rtl/mxdiv_sched.sv
// Sequencer for A * inv(B): launches the inverter, then the multiplier,
// guarding each wait with a watchdog and reporting errors.
module mxdiv_sched
  import mxdiv_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       doneInv,
  input  logic       singular,
  input  logic       doneMulmx,
  output logic       startInv,
  output logic       startMulmx,
  output logic       selMx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] errCode,
  output logic [2:0] phase
);

  state_t     state;
  state_t     nextState;
  logic [1:0] nextErrCode;
  logic       wdClear;
  logic       wdEnable;
  logic       wdExpired;

  assign wdClear  = isLaunchState(state);
  assign wdEnable = isWaitState(state);

  mxdiv_wdog #(
    .LIMIT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wdClear),
    .enable (wdEnable),
    .expired(wdExpired)
  );

  // Done pulses are tested before expiry so a same-cycle completion wins.
  always_comb begin
    nextState   = state;
    nextErrCode = errCode;
    case (state)
      IDLE: begin
        if (start) nextState = INV_START;
      end
      INV_START: nextState = INV_WAIT;
      INV_WAIT: begin
        if (doneInv) begin
          if (singular) begin
            nextState   = ERR;
            nextErrCode = ERR_SINGULAR;
          end else begin
            nextState = MUL_START;
          end
        end else if (wdExpired) begin
          nextState   = ERR;
          nextErrCode = ERR_INV_TIMEOUT;
        end
      end
      MUL_START: nextState = MUL_WAIT;
      MUL_WAIT: begin
        if (doneMulmx) begin
          nextState   = DONE;
          nextErrCode = ERR_NONE;
        end else if (wdExpired) begin
          nextState   = ERR;
          nextErrCode = ERR_MUL_TIMEOUT;
        end
      end
      DONE: nextState = IDLE;
      ERR: begin
        if (start) begin
          nextState   = INV_START;
          nextErrCode = ERR_NONE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so they always match the registered state without combinational glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      errCode    <= ERR_NONE;
      startInv   <= 1'b0;
      startMulmx <= 1'b0;
      selMx      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= nextState;
      errCode    <= nextErrCode;
      startInv   <= (nextState == INV_START);
      startMulmx <= (nextState == MUL_START);
      selMx      <= (nextState == MUL_START) || (nextState == MUL_WAIT) ||
                    (nextState == DONE);
      busy       <= (nextState == INV_START) || (nextState == INV_WAIT) ||
                    (nextState == MUL_START) || (nextState == MUL_WAIT);
      done       <= (nextState == DONE);
      err        <= (nextState == ERR);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_mxdiv_sched.sv
// Directed scoreboard bench for mxdiv_sched: instance 0 uses the default
// watchdog limit, instance 1 uses TIMEOUT=10 for the expiry scenarios.
module tb_mxdiv_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start      [2];
  logic       doneInv    [2];
  logic       singular   [2];
  logic       doneMulmx  [2];
  logic       startInv   [2];
  logic       startMulmx [2];
  logic       selMx      [2];
  logic       busy       [2];
  logic       done       [2];
  logic       err        [2];
  logic [1:0] errCode    [2];
  logic [2:0] phase      [2];

  typedef struct {
    logic       isErr;
    logic [1:0] code;
  } result_t;

  result_t expQ[$];
  int total = 0;
  int bad   = 0;
  int nStartInv [2] = '{0, 0};
  int nStartMul [2] = '{0, 0};
  int nDone     [2] = '{0, 0};

  always #5 clk = ~clk;

  mxdiv_sched u0 (
    .clk(clk), .rst(rst), .start(start[0]), .doneInv(doneInv[0]),
    .singular(singular[0]), .doneMulmx(doneMulmx[0]), .startInv(startInv[0]),
    .startMulmx(startMulmx[0]), .selMx(selMx[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .errCode(errCode[0]), .phase(phase[0])
  );

  mxdiv_sched #(.TIMEOUT(10)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .doneInv(doneInv[1]),
    .singular(singular[1]), .doneMulmx(doneMulmx[1]), .startInv(startInv[1]),
    .startMulmx(startMulmx[1]), .selMx(selMx[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .errCode(errCode[1]), .phase(phase[1])
  );

  // Pulse counters see the value held during the cycle that just ended.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (startInv[u] === 1'b1)   nStartInv[u]++;
      if (startMulmx[u] === 1'b1) nStartMul[u]++;
      if (done[u] === 1'b1)       nDone[u]++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int u, input logic s, input logic di,
                               input logic sg, input logic dm);
    start[u]     = s;
    doneInv[u]   = di;
    singular[u]  = sg;
    doneMulmx[u] = dm;
    @(negedge clk);
    start[u]     = 1'b0;
    doneInv[u]   = 1'b0;
    singular[u]  = 1'b0;
    doneMulmx[u] = 1'b0;
  endtask

  task automatic waitResult(input int u, input int budget, input string tag);
    int n = 0;
    result_t e;
    while (!(done[u] === 1'b1 || err[u] === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_seen"}, 32'(done[u] === 1'b1 || err[u] === 1'b1), 1);
    checkOutput({tag, "_queued"}, 32'(expQ.size() != 0), 1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_err"}, err[u], e.isErr);
      checkOutput({tag, "_done"}, done[u], !e.isErr);
      checkOutput({tag, "_code"}, errCode[u], e.code);
    end
  endtask

  task automatic countWait(input int u, input logic [2:0] waitCode, output int n);
    n = 0;
    while (phase[u] === waitCode && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int si, sm, dn, n;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; doneInv[u] = 1'b0; singular[u] = 1'b0; doneMulmx[u] = 1'b0;
    end
    tick(2);
    for (int u = 0; u < 2; u++) begin
      checkOutput("rst_phase", phase[u], 0);
      checkOutput("rst_busy", busy[u], 0);
      checkOutput("rst_selMx", selMx[u], 0);
      checkOutput("rst_err", err[u], 0);
      checkOutput("rst_errCode", errCode[u], 0);
      checkOutput("rst_startInv", startInv[u], 0);
      checkOutput("rst_done", done[u], 0);
    end
    rst = 1'b0;
    tick(1);

    $display("[TB] nominal run");
    si = nStartInv[0]; sm = nStartMul[0]; dn = nDone[0];
    expQ.push_back('{1'b0, 2'b00});
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("nom_startInv", startInv[0], 1);
    checkOutput("nom_busy", busy[0], 1);
    checkOutput("nom_selMx_inv", selMx[0], 0);
    tick(1);
    checkOutput("nom_phase_invwait", phase[0], 2);
    checkOutput("nom_startInv_gone", startInv[0], 0);
    tick(3);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("nom_startMulmx", startMulmx[0], 1);
    checkOutput("nom_selMx_mul", selMx[0], 1);
    tick(15);
    checkOutput("nom_phase_mulwait", phase[0], 4);
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(0, 5, "nom");
    tick(1);
    checkOutput("nom_phase_idle", phase[0], 0);
    checkOutput("nom_busy_end", busy[0], 0);
    checkOutput("nom_cnt_startInv", nStartInv[0] - si, 1);
    checkOutput("nom_cnt_startMul", nStartMul[0] - sm, 1);
    checkOutput("nom_cnt_done", nDone[0] - dn, 1);

    $display("[TB] singular B");
    sm = nStartMul[0];
    expQ.push_back('{1'b1, 2'b01});
    applyStimulus(0, 1, 0, 0, 0);
    tick(2);
    applyStimulus(0, 0, 1, 1, 0);
    waitResult(0, 5, "sing");
    checkOutput("sing_phase", phase[0], 6);
    tick(3);
    checkOutput("sing_err_held", err[0], 1);
    checkOutput("sing_no_startMul", nStartMul[0] - sm, 0);
    expQ.push_back('{1'b0, 2'b00});
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("sing_restart_code", errCode[0], 0);
    checkOutput("sing_restart_startInv", startInv[0], 1);
    checkOutput("sing_restart_err", err[0], 0);
    tick(1);
    applyStimulus(0, 0, 1, 0, 0);
    tick(1);
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(0, 5, "sing_rerun");
    tick(1);

    $display("[TB] spurious inputs");
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("spur_idle_mul_phase", phase[0], 0);
    checkOutput("spur_idle_mul_done", done[0], 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("spur_idle_inv_phase", phase[0], 0);
    checkOutput("spur_idle_inv_err", err[0], 0);
    si = nStartInv[0]; dn = nDone[0];
    expQ.push_back('{1'b0, 2'b00});
    applyStimulus(0, 1, 0, 0, 0);
    tick(1);
    applyStimulus(0, 0, 1, 0, 0);
    tick(1);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("spur_mulwait_phase", phase[0], 4);
    checkOutput("spur_mulwait_startInv", startInv[0], 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("spur_mulwait_inv_phase", phase[0], 4);
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(0, 5, "spur");
    tick(1);
    checkOutput("spur_cnt_startInv", nStartInv[0] - si, 1);
    checkOutput("spur_cnt_done", nDone[0] - dn, 1);

    $display("[TB] inverter timeout");
    expQ.push_back('{1'b1, 2'b10});
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    countWait(1, 3'd2, n);
    checkOutput("invto_cycles", n, 10);
    waitResult(1, 3, "invto");

    $display("[TB] multiplier timeout");
    expQ.push_back('{1'b1, 2'b11});
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("multo_code_cleared", errCode[1], 0);
    tick(1);
    applyStimulus(1, 0, 1, 0, 0);
    tick(1);
    countWait(1, 3'd4, n);
    checkOutput("multo_cycles", n, 10);
    waitResult(1, 3, "multo");

    $display("[TB] done versus expiry race");
    expQ.push_back('{1'b0, 2'b00});
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    applyStimulus(1, 0, 1, 0, 0);
    tick(1);
    tick(9);
    checkOutput("race_phase_before", phase[1], 4);
    applyStimulus(1, 0, 0, 0, 1);
    waitResult(1, 1, "race");
    tick(1);

    $display("[TB] reset abort");
    dn = nDone[0];
    applyStimulus(0, 1, 0, 0, 0);
    tick(1);
    applyStimulus(0, 0, 1, 0, 0);
    tick(3);
    checkOutput("rabort_phase_pre", phase[0], 4);
    #2 rst = 1'b1;
    #1;
    checkOutput("rabort_phase", phase[0], 0);
    checkOutput("rabort_busy", busy[0], 0);
    checkOutput("rabort_selMx", selMx[0], 0);
    checkOutput("rabort_err", err[0], 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    checkOutput("rabort_no_done", nDone[0] - dn, 0);
    expQ.push_back('{1'b0, 2'b00});
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("rabort_rerun_startInv", startInv[0], 1);
    tick(1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("rabort_rerun_startMul", startMulmx[0], 1);
    tick(2);
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(0, 5, "rabort_rerun");

    checkOutput("queue_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mxdiv_sched.md
MXDIV_SCHED -- requirements
Module: mxdiv_sched

Interface
REQ-001 Parameter TIMEOUT, 63, watchdog limit in cycles for each wait phase (range 1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to run one divide (A * inv(B)); sampled only in IDLE or ERR.
REQ-005 doneInv  input  1  one-cycle pulse from the inverter: inv(B) has been written.
REQ-006 singular  input  1  inverter flag; valid in the cycle doneInv is high.
REQ-007 doneMulmx  input  1  one-cycle pulse from the multiply sequencer: last result word written.
REQ-008 startInv  output  1  one-cycle launch pulse to the inverter.
REQ-009 startMulmx  output  1  one-cycle launch pulse to the multiply sequencer.
REQ-010 selMx  output  1  matrix-RAM write-port owner: 0 = inverter, 1 = multiplier.
REQ-011 busy  output  1  high from INV_START through MUL_WAIT inclusive.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 err  output  1  held high while in ERR.
REQ-014 errCode  output  2  00 none, 01 singular B, 10 inverter timeout, 11 multiplier timeout.
REQ-015 phase  output  3  current state encoding, for debug.

Function
REQ-016 The FSM SHALL have the states IDLE, INV_START, INV_WAIT, MUL_START, MUL_WAIT, DONE and ERR; all outputs SHALL be Moore-decoded from the registered state, except errCode, which is a register.
REQ-017 IDLE: start=1 -> INV_START at the next edge; start=0 -> stay in IDLE.
REQ-018 INV_START: startInv=1 for exactly one cycle, then INV_WAIT unconditionally.
REQ-019 INV_WAIT: doneInv=1 and singular=1 -> ERR with errCode=01; doneInv=1 and singular=0 -> MUL_START.
REQ-020 MUL_START: startMulmx=1 for exactly one cycle, then MUL_WAIT unconditionally.
REQ-021 MUL_WAIT: doneMulmx=1 -> DONE.
REQ-022 DONE: done=1 for one cycle, then IDLE; errCode SHALL clear to 00 on entry to DONE.
REQ-023 ERR: err=1 until start=1; start=1 SHALL clear errCode and go directly to INV_START.
REQ-024 selMx SHALL be 1 in MUL_START, MUL_WAIT and DONE, and 0 in all other states.
REQ-025 The watchdog counter SHALL clear on entry to INV_WAIT and on entry to MUL_WAIT, and SHALL increment once per cycle while in either wait state.
REQ-026 When the count reaches TIMEOUT with no done pulse, the FSM SHALL go to ERR with errCode=10 from INV_WAIT or 11 from MUL_WAIT.
REQ-027 If a done pulse and watchdog expiry occur in the same cycle, the done pulse SHALL win.
REQ-028 start SHALL be ignored in INV_START, INV_WAIT, MUL_START, MUL_WAIT and DONE; no queuing.
REQ-029 doneInv outside INV_WAIT, doneMulmx outside MUL_WAIT, and singular without doneInv SHALL be ignored.
REQ-030 Minimum latency: start edge -> startInv high 1 cycle later; doneMulmx edge -> done high 1 cycle later.
REQ-031 The watchdog counter SHALL be 8 bits wide and SHALL saturate, never wrap.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, counter=0 and errCode=00; all outputs are then 0 (phase = IDLE code).
REQ-033 Reset asserted mid-operation SHALL abort the operation with no done or err pulse; the first start after rst deasserts SHALL run normally.

Structure
REQ-034 A shared package SHALL hold the state encodings (IDLE=0 .. ERR=6), the errCode constants and the TIMEOUT default.
REQ-035 The watchdog SHALL be one sub-module, mxdiv_wdog (inputs clear and enable; output expired), instantiated once.

Verification
REQ-036 Nominal run: start; doneInv 5 cycles after startInv with singular=0; doneMulmx 16 cycles after startMulmx -> one startInv, one startMulmx, one done, err=0, selMx 0 then 1.
REQ-037 Singular B: doneInv with singular=1 -> err=1, errCode=01, no startMulmx; a later start -> errCode=00 and startInv 1 cycle later.
REQ-038 Timeouts, TIMEOUT=10: doneInv never arrives -> ERR with errCode=10 after exactly 10 INV_WAIT cycles; repeat for MUL_WAIT -> errCode=11.
REQ-039 Same-cycle race: doneMulmx on the expiry cycle -> done=1, err=0.
REQ-040 Spurious inputs: start pulses during MUL_WAIT and doneMulmx during IDLE -> no state change and no extra pulses.
REQ-041 Reset abort: rst in MUL_WAIT -> IDLE asynchronously, all outputs 0, no done; the next start runs the full sequence.
